// File: rtl/control_sequencer.sv
// control_sequencer
//
// Program-counter driven control sequencer. It fetches instructions from a
// synchronous instruction ROM, decodes them, and issues one-cycle strobes to
// the systolic array / unified buffer. It also holds a base address and runs
// a loop counter that supports decrement-and-branch. After issuing VALID it
// waits for the array's compute_done handshake.
//
// Parameters
//   INSTR_W   instruction width
//   OPCODE_W  opcode field width, instr[INSTR_W-1 -: OPCODE_W]
//   ADDR_W    immediate width, instr[ADDR_W-1:0]; equals INSTR_W-OPCODE_W
//   PC_W      program counter width (PC_W <= ADDR_W)
//   LOOP_W    loop counter width (LOOP_W <= ADDR_W-1)
//
// Ports
//   clk           clock, all logic on the rising edge
//   reset         synchronous, active-low reset
//   start         begin execution from pc=0; honoured only in IDLE / HALTED
//   instr_addr    ROM address (always equal to pc)
//   instr_data    ROM data, valid one cycle after instr_addr
//   compute_done  array finished the issued compute; level, sampled in WAIT
//   base_address  registered base address, held until the next LOAD_ADDR
//   load_weight   one-cycle strobe
//   load_input    one-cycle strobe
//   valid         one-cycle strobe that starts a compute
//   store         one-cycle strobe
//   busy          high in FETCH, EXEC and WAIT
//   halted        high in HALTED
//   pc            current program counter
module control_sequencer #(
    parameter int INSTR_W  = 16,
    parameter int OPCODE_W = 3,
    parameter int ADDR_W   = 13,
    parameter int PC_W     = 8,
    parameter int LOOP_W   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [PC_W-1:0]     instr_addr,
    input  logic [INSTR_W-1:0]  instr_data,
    input  logic                compute_done,
    output logic [ADDR_W-1:0]   base_address,
    output logic                load_weight,
    output logic                load_input,
    output logic                valid,
    output logic                store,
    output logic                busy,
    output logic                halted,
    output logic [PC_W-1:0]     pc
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        WAIT   = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_NOP          = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LOAD_ADDR    = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_LOAD_WEIGHT  = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_LOAD_INPUTS  = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_VALID        = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_STORE        = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_LOOP         = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_HALT         = OPCODE_W'(7);

    state_t              state;
    logic [LOOP_W-1:0]   loop_cnt;
    logic [OPCODE_W-1:0] opcode;
    logic [ADDR_W-1:0]   imm;
    logic [PC_W-1:0]     pc_inc;

    assign opcode     = instr_data[INSTR_W-1 -: OPCODE_W];
    assign imm        = instr_data[ADDR_W-1:0];
    // Wraps modulo 2^PC_W by construction.
    assign pc_inc     = pc + PC_W'(1);

    // The ROM address is the pc itself, so the ROM samples it in FETCH and
    // the word is ready in EXEC.
    assign instr_addr = pc;
    assign busy       = (state == FETCH) || (state == EXEC) || (state == WAIT);
    assign halted     = (state == HALTED);

    // NOTE: all state is updated with non-blocking assignments so every
    // decision in a cycle sees the register values from the start of it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= '0;
            loop_cnt     <= '0;
            base_address <= '0;
            load_weight  <= 1'b0;
            load_input   <= 1'b0;
            valid        <= 1'b0;
            store        <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle. Only EXEC raises one, so
            // each strobe lasts exactly the one cycle after EXEC.
            load_weight <= 1'b0;
            load_input  <= 1'b0;
            valid       <= 1'b0;
            store       <= 1'b0;

            case (state)
                IDLE, HALTED: begin
                    // loop_cnt and base_address are kept across a restart.
                    if (start) begin
                        state <= FETCH;
                        pc    <= '0;
                    end
                end

                FETCH: state <= EXEC;

                EXEC: begin
                    state <= FETCH;
                    pc    <= pc_inc;
                    case (opcode)
                        OP_NOP:         ;
                        OP_LOAD_ADDR:   base_address <= imm;
                        OP_LOAD_WEIGHT: load_weight  <= 1'b1;
                        OP_LOAD_INPUTS: load_input   <= 1'b1;
                        OP_VALID: begin
                            // pc stays on the VALID until the array reports done.
                            valid <= 1'b1;
                            pc    <= pc;
                            state <= WAIT;
                        end
                        OP_STORE:       store <= 1'b1;
                        OP_LOOP: begin
                            if (!imm[ADDR_W-1]) begin
                                loop_cnt <= imm[LOOP_W-1:0];
                            end else if (loop_cnt != '0) begin
                                // Taken DJNZ. An exhausted counter falls through
                                // and stays at zero.
                                loop_cnt <= loop_cnt - LOOP_W'(1);
                                pc       <= imm[PC_W-1:0];
                            end
                        end
                        OP_HALT: begin
                            pc    <= pc;
                            state <= HALTED;
                        end
                        default: ;
                    endcase
                end

                WAIT: begin
                    // compute_done is checked from the first WAIT cycle,
                    // which is the same cycle that valid is high.
                    if (compute_done) begin
                        state <= FETCH;
                        pc    <= pc_inc;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer
//
// Bench for control_sequencer with PC_W=4, so the pc wrap can be reached
// quickly. A synchronous ROM model feeds instructions to the sequencer. In
// wrap mode the ROM returns HALT at address 0 once the pc has wrapped from
// 15 back to 0. Each test pushes the strobes it expects, with their kind and
// their cycle relative to start, onto a scoreboard. A negedge monitor pops
// and compares every strobe the sequencer emits.
module tb_control_sequencer;

    localparam int INSTR_W  = 16;
    localparam int OPCODE_W = 3;
    localparam int ADDR_W   = 13;
    localparam int PC_W     = 4;
    localparam int LOOP_W   = 8;

    typedef enum logic [1:0] {S_LW, S_LI, S_VALID, S_STORE} strobe_e;
    typedef struct {
        strobe_e kind;
        int      rel;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic               compute_done = 1'b0;
    logic [PC_W-1:0]    instr_addr;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  base_address;
    logic               load_weight, load_input, valid, store, busy, halted;
    logic [PC_W-1:0]    pc;

    logic [INSTR_W-1:0] rom [16];
    logic               wrap_mode = 1'b0;
    logic               wrapped = 1'b0;
    logic [PC_W-1:0]    prev_addr = '0;

    exp_t sb[$];
    int   cyc = 0;
    int   t0 = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    control_sequencer #(
        .INSTR_W(INSTR_W), .OPCODE_W(OPCODE_W), .ADDR_W(ADDR_W),
        .PC_W(PC_W), .LOOP_W(LOOP_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .compute_done(compute_done), .base_address(base_address),
        .load_weight(load_weight), .load_input(load_input),
        .valid(valid), .store(store), .busy(busy), .halted(halted), .pc(pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [INSTR_W-1:0] mk(input logic [2:0] op, input logic [ADDR_W-1:0] imm);
        return {op, imm};
    endfunction

    // Synchronous instruction ROM.
    always @(posedge clk) begin
        if (!wrap_mode)
            wrapped <= 1'b0;
        else if (prev_addr == 4'd15 && instr_addr == 4'd0)
            wrapped <= 1'b1;
        prev_addr  <= instr_addr;
        instr_data <= (wrap_mode && instr_addr == 4'd0 && (wrapped || prev_addr == 4'd15))
                      ? mk(3'b111, '0) : rom[instr_addr];
    end

    // Scoreboard monitor: every strobe cycle is one comparison.
    always @(negedge clk) begin : monitor
        int      n_high;
        strobe_e got;
        exp_t    e;
        n_high = $countones({store, valid, load_input, load_weight});
        if (n_high > 0) begin
            n_checks++;
            if (load_weight === 1'b1)      got = S_LW;
            else if (load_input === 1'b1)  got = S_LI;
            else if (valid === 1'b1)       got = S_VALID;
            else                           got = S_STORE;
            if (n_high > 1) begin
                n_fail++;
                $display("FAIL strobe_onehot: %0d strobes high at rel cycle %0d, want 1", n_high, cyc - t0);
            end else if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected: got %s at rel cycle %0d, want none", got.name(), cyc - t0);
            end else begin
                e = sb.pop_front();
                if (e.kind !== got || e.rel != cyc - t0) begin
                    n_fail++;
                    $display("FAIL strobe_event: got %s at rel %0d, want %s at rel %0d",
                             got.name(), cyc - t0, e.kind.name(), e.rel);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1, "watchdog");
    end

    // Advance to the negedge inside relative cycle n (cycle 0 = start sampled).
    task automatic wait_rel(input int n);
        while (cyc < t0 + n || clk !== 1'b0) @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        t0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic load_rom(input logic [INSTR_W-1:0] w0, w1, w2, w3);
        for (int i = 0; i < 16; i++) rom[i] = mk(3'b111, '0);
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    endtask

    task automatic check_sb_empty(input string name);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_missing_strobes: %0d pending, want 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, halted, load_weight, load_input, valid, store} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, want 000000", {busy, halted, load_weight, load_input, valid, store});
        end
        n_checks++;
        if (pc !== 4'd0 || instr_addr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_pc: got pc=%0d addr=%0d, want 0", pc, instr_addr);
        end
        n_checks++;
        if (base_address !== 13'd0 || dut.loop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got base=%h loop=%0d, want 0", base_address, dut.loop_cnt);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || pc !== 4'd0) begin
            n_fail++;
            $display("FAIL idle_hold: got busy=%b pc=%0d, want 0 0", busy, pc);
        end
    endtask

    task automatic test_load_addr_weight();
        load_rom(mk(3'b001, 13'h0ABC), mk(3'b010, '0), mk(3'b111, '0), mk(3'b111, '0));
        sb.push_back('{S_LW, 5});
        do_start();
        wait_rel(2);
        n_checks++;
        if (base_address !== 13'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL base_before: got base=%h busy=%b, want 0000 1", base_address, busy);
        end
        wait_rel(3);
        n_checks++;
        if (base_address !== 13'h0ABC) begin
            n_fail++;
            $display("FAIL base_loaded: got %h, want 0abc", base_address);
        end
        wait_rel(7);
        n_checks++;
        if (halted !== 1'b1 || busy !== 1'b0 || pc !== 4'd2) begin
            n_fail++;
            $display("FAIL halt_1: got halted=%b busy=%b pc=%0d, want 1 0 2", halted, busy, pc);
        end
        check_sb_empty("prog1");
    endtask

    task automatic test_compute_wait();
        load_rom(mk(3'b100, '0), mk(3'b101, '0), mk(3'b111, '0), mk(3'b111, '0));
        sb.push_back('{S_VALID, 3});
        sb.push_back('{S_STORE, 10});
        do_start();
        for (int n = 3; n <= 7; n++) begin
            wait_rel(n);
            if (n == 4) start = 1'b1;   // ignored while busy
            if (n == 5) start = 1'b0;
            if (n == 7) compute_done = 1'b1;
            n_checks++;
            if (busy !== 1'b1 || pc !== 4'd0) begin
                n_fail++;
                $display("FAIL wait_hold cyc %0d: got busy=%b pc=%0d, want 1 0", n, busy, pc);
            end
        end
        wait_rel(8);
        compute_done = 1'b0;
        n_checks++;
        if (pc !== 4'd1) begin
            n_fail++;
            $display("FAIL wait_exit_pc: got %0d, want 1", pc);
        end
        wait_rel(12);
        n_checks++;
        if (halted !== 1'b1 || pc !== 4'd2) begin
            n_fail++;
            $display("FAIL halt_2: got halted=%b pc=%0d, want 1 2", halted, pc);
        end
        check_sb_empty("compute_wait");
    endtask

    task automatic test_immediate_done();
        compute_done = 1'b1;
        sb.push_back('{S_VALID, 3});
        sb.push_back('{S_STORE, 6});
        do_start();
        wait_rel(3);
        n_checks++;
        if (busy !== 1'b1 || pc !== 4'd0) begin
            n_fail++;
            $display("FAIL imm_wait: got busy=%b pc=%0d, want 1 0", busy, pc);
        end
        wait_rel(4);
        n_checks++;
        if (pc !== 4'd1) begin
            n_fail++;
            $display("FAIL imm_exit_pc: got %0d, want 1", pc);
        end
        wait_rel(8);
        compute_done = 1'b0;
        n_checks++;
        if (halted !== 1'b1 || pc !== 4'd2) begin
            n_fail++;
            $display("FAIL halt_3: got halted=%b pc=%0d, want 1 2", halted, pc);
        end
        check_sb_empty("immediate_done");
    endtask

    task automatic test_loop();
        load_rom(mk(3'b110, 13'd2), mk(3'b011, '0), mk(3'b110, 13'h1001), mk(3'b111, '0));
        sb.push_back('{S_LI, 5});
        sb.push_back('{S_LI, 9});
        sb.push_back('{S_LI, 13});
        do_start();
        wait_rel(3);
        n_checks++;
        if (dut.loop_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL setcnt: got %0d, want 2", dut.loop_cnt);
        end
        wait_rel(7);
        n_checks++;
        if (dut.loop_cnt !== 8'd1 || pc !== 4'd1) begin
            n_fail++;
            $display("FAIL djnz_taken: got loop=%0d pc=%0d, want 1 1", dut.loop_cnt, pc);
        end
        wait_rel(15);
        n_checks++;
        if (pc !== 4'd3 || dut.loop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL djnz_fall: got pc=%0d loop=%0d, want 3 0", pc, dut.loop_cnt);
        end
        wait_rel(17);
        n_checks++;
        if (halted !== 1'b1 || pc !== 4'd3 || dut.loop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL halt_loop: got halted=%b pc=%0d loop=%0d, want 1 3 0", halted, pc, dut.loop_cnt);
        end
        check_sb_empty("loop");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) rom[i] = mk(3'b000, '0);
        wrap_mode = 1'b1;
        do_start();
        wait_rel(1);
        n_checks++;
        if (pc !== 4'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_pc: got pc=%0d busy=%b, want 0 1", pc, busy);
        end
        wait_rel(31);
        n_checks++;
        if (pc !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_pc15: got %0d, want 15", pc);
        end
        wait_rel(33);
        n_checks++;
        if (pc !== 4'd0 || busy !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_pc0: got pc=%0d busy=%b halted=%b, want 0 1 0", pc, busy, halted);
        end
        wait_rel(35);
        n_checks++;
        if (halted !== 1'b1 || pc !== 4'd0) begin
            n_fail++;
            $display("FAIL wrap_halt: got halted=%b pc=%0d, want 1 0", halted, pc);
        end
        wrap_mode = 1'b0;
        check_sb_empty("wrap");
    endtask

    task automatic test_reset_mid_wait();
        load_rom(mk(3'b001, 13'h0123), mk(3'b100, '0), mk(3'b000, '0), mk(3'b111, '0));
        sb.push_back('{S_VALID, 5});
        do_start();
        wait_rel(6);
        n_checks++;
        if (busy !== 1'b1 || pc !== 4'd1 || base_address !== 13'h0123) begin
            n_fail++;
            $display("FAIL pre_reset: got busy=%b pc=%0d base=%h, want 1 1 0123", busy, pc, base_address);
        end
        reset = 1'b0;
        wait_rel(7);
        reset = 1'b1;
        n_checks++;
        if (busy !== 1'b0 || halted !== 1'b0 || pc !== 4'd0 || base_address !== 13'd0) begin
            n_fail++;
            $display("FAIL post_reset: got busy=%b halted=%b pc=%0d base=%h, want 0 0 0 0000",
                     busy, halted, pc, base_address);
        end
        compute_done = 1'b1;
        wait_rel(11);
        compute_done = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || pc !== 4'd0) begin
            n_fail++;
            $display("FAIL done_ignored: got busy=%b pc=%0d, want 0 0", busy, pc);
        end
        check_sb_empty("reset_mid_wait");
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = mk(3'b111, '0);
        test_reset();
        test_load_addr_weight();
        test_compute_wait();
        test_immediate_done();
        test_loop();
        test_wrap();
        test_reset_mid_wait();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
